// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings,
// register-index width, the reg-0 constant and the bundle of enable and
// flush controls the controller drives.
package pipe_ctrl_pkg;

  // Register-file index width and the hard-wired zero register.
  localparam int                REG_W    = 4;
  localparam logic [REG_W-1:0]  REG_ZERO = '0;

  // Controller FSM states.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_IMISS = 2'd1;
  localparam logic [1:0] ST_DMISS = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Width of the optional stall-cycle performance counter.
  localparam int PERF_W = 16;

  // Pipeline control outputs, kept together so each case picks one pattern.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  // Everything advances, nothing flushed.
  localparam ctrl_t CTRL_RUN    = 6'b1111_00;
  // Whole pipeline frozen while a data-cache fill is outstanding.
  localparam ctrl_t CTRL_FREEZE = 6'b0000_00;
  // Hold PC and IF/ID, inject a bubble into ID/EX, let EX and MEM drain.
  localparam ctrl_t CTRL_BUBBLE = 6'b0011_01;
  // Taken branch resolved in ID: squash the wrong-path fetch in IF/ID.
  localparam ctrl_t CTRL_BRANCH = 6'b1111_10;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// destination of a load currently in EX. Writes to register 0 never
// create a dependency. Purely combinational.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_rs_used && (id_rs == ex_rd);
  assign rt_hit   = id_rt_used && (id_rt == ex_rd);
  assign load_use = ex_memread && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order pipeline.
// Tracks instruction-cache misses, data-cache misses (which may nest inside
// an instruction miss) and HLT, and decodes PC / pipeline-register enables
// and bubble/flush requests. Optional feature: define PIPE_CTRL_PERF_EN to
// add the saturating stall_cycles performance counter output.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  input  logic             icache_miss,
  input  logic             icache_fill_done,
  input  logic             dcache_miss,
  input  logic             dcache_fill_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles
`endif
);

  logic [1:0] state_q, state_d;
  logic       imiss_pend_q, imiss_pend_d;
  logic       halted_q;
  logic       load_use;
  ctrl_t      ctrl;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // Next-state and output decode, highest-priority event first.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    imiss_pend_d = imiss_pend_q;
    ctrl         = CTRL_RUN;
    case (state_q)
      ST_RUN: begin
        if (dcache_miss) begin
          ctrl         = CTRL_FREEZE;
          state_d      = ST_DMISS;
          imiss_pend_d = 1'b0;
        end else if (icache_miss) begin
          ctrl    = CTRL_BUBBLE;
          state_d = ST_IMISS;
        end else if (load_use) begin
          // The stall wins over a taken branch; the branch re-resolves
          // next cycle once the load data is available.
          ctrl = CTRL_BUBBLE;
        end else if (id_branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (id_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_IMISS: begin
        if (dcache_miss) begin
          // Remember the instruction fill unless it completes this cycle.
          ctrl         = CTRL_FREEZE;
          state_d      = ST_DMISS;
          imiss_pend_d = !icache_fill_done;
        end else begin
          // Branch, load-use and halt are ignored while fetch is stalled.
          ctrl = CTRL_BUBBLE;
          if (icache_fill_done) state_d = ST_RUN;
        end
      end
      ST_DMISS: begin
        ctrl = CTRL_FREEZE;
        if (icache_fill_done) imiss_pend_d = 1'b0;
        if (dcache_fill_done) begin
          state_d      = (imiss_pend_q && !icache_fill_done) ? ST_IMISS : ST_RUN;
          imiss_pend_d = 1'b0;
        end
      end
      default: begin
        // HALT: drain EX/MEM, hold fetch; only reset leaves this state.
        ctrl = CTRL_BUBBLE;
      end
    endcase
    // Outputs read as a free-running pipeline while reset is held.
    if (!rst) ctrl = CTRL_RUN;
  end

  // FSM state, pending-instruction-miss flag and registered halted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      imiss_pend_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples values from before this edge, independent of statement order.
      state_q      <= state_d;
      imiss_pend_q <= imiss_pend_d;
      halted_q     <= (state_d == ST_HALT);
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_q;

  // Count cycles where fetch is stalled by a hazard or miss (not by HLT).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!ctrl.pc_en && (state_q != ST_HALT) && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign halted     = halted_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios for each feature,
// then randomized stimulus against a behavioural model of the controller.
// Define PIPE_CTRL_PERF_EN to also exercise the stall_cycles counter.
module tb_pipe_ctrl;

  // Observation word: {halted, state[1:0], pc_en, ifid_en, exmem_en,
  //                    memwb_en, ifid_flush, idex_flush}
  localparam logic [8:0] OBS_RUN = 9'b0_00_111100;
  localparam logic [8:0] OBS_BUB = 9'b0_00_001101;
  localparam logic [8:0] OBS_BR  = 9'b0_00_111110;
  localparam logic [8:0] OBS_FRZ = 9'b0_00_000000;
  localparam logic [8:0] OBS_IM  = 9'b0_01_001101;
  localparam logic [8:0] OBS_IMD = 9'b0_01_000000;
  localparam logic [8:0] OBS_DM  = 9'b0_10_000000;
  localparam logic [8:0] OBS_HLT = 9'b1_11_001101;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_rs_used, id_rt_used, ex_memread;
  logic       id_branch_taken, id_halt;
  logic       icache_miss, icache_fill_done, dcache_miss, dcache_fill_done;
  logic       pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic       halted;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cycles;
`endif
  logic [8:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {halted, state, pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_rs_used       (id_rs_used),
    .id_rt_used       (id_rt_used),
    .ex_memread       (ex_memread),
    .ex_rd            (ex_rd),
    .id_branch_taken  (id_branch_taken),
    .id_halt          (id_halt),
    .icache_miss      (icache_miss),
    .icache_fill_done (icache_fill_done),
    .dcache_miss      (dcache_miss),
    .dcache_fill_done (dcache_fill_done),
    .pc_en            (pc_en),
    .ifid_en          (ifid_en),
    .exmem_en         (exmem_en),
    .memwb_en         (memwb_en),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .halted           (halted),
    .state            (state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  task automatic idle();
    id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_memread = 1'b0;
    id_branch_taken = 1'b0; id_halt = 1'b0;
    icache_miss = 1'b0; icache_fill_done = 1'b0;
    dcache_miss = 1'b0; dcache_fill_done = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    dcache_miss = 1'b1; ex_memread = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
    #2;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL reset_outputs obs=%b want=%b", obs, OBS_RUN); end
    tick(); tick();
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL reset_held obs=%b want=%b", obs, OBS_RUN); end
    rst = 1'b1;
    idle();
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL reset_release obs=%b want=%b", obs, OBS_RUN); end
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1; id_branch_taken = 1'b1;
    #1;
    checks++; if (obs !== OBS_BUB) begin errors++; $display("FAIL lu_rs_stall obs=%b want=%b", obs, OBS_BUB); end
    tick();
    ex_memread = 1'b0; id_branch_taken = 1'b0;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL lu_one_cycle obs=%b want=%b", obs, OBS_RUN); end
    ex_memread = 1'b1; ex_rd = 4'd0; id_rs = 4'd0;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL lu_reg0 obs=%b want=%b", obs, OBS_RUN); end
    ex_rd = 4'd5; id_rs = 4'd5; id_rs_used = 1'b0; id_rt = 4'd5; id_rt_used = 1'b1;
    #1;
    checks++; if (obs !== OBS_BUB) begin errors++; $display("FAIL lu_rt_stall obs=%b want=%b", obs, OBS_BUB); end
    id_rt_used = 1'b0;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL lu_unused obs=%b want=%b", obs, OBS_RUN); end
    id_rs_used = 1'b1; ex_memread = 1'b0;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL lu_not_load obs=%b want=%b", obs, OBS_RUN); end
    tick();
    idle();
  endtask

  task automatic test_branch();
    idle();
    id_branch_taken = 1'b1;
    #1;
    checks++; if (obs !== OBS_BR) begin errors++; $display("FAIL br_flush obs=%b want=%b", obs, OBS_BR); end
    tick();
    idle();
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL br_after obs=%b want=%b", obs, OBS_RUN); end
  endtask

  task automatic test_imiss();
    idle();
    icache_miss = 1'b1;
    #1;
    checks++; if (obs !== OBS_BUB) begin errors++; $display("FAIL im_enter obs=%b want=%b", obs, OBS_BUB); end
    tick();
    for (int i = 0; i < 5; i++) begin
      idle();
      id_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 4'd2; id_rs = 4'd2; id_rs_used = 1'b1;
      icache_fill_done = (i == 4);
      #1;
      checks++; if (obs !== OBS_IM) begin errors++; $display("FAIL im_wait%0d obs=%b want=%b", i, obs, OBS_IM); end
      tick();
    end
    idle();
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL im_exit obs=%b want=%b", obs, OBS_RUN); end
  endtask

  task automatic test_nested_miss();
    // Data miss nested in an instruction miss returns to IMISS.
    idle(); icache_miss = 1'b1; tick(); idle();
    #1;
    checks++; if (obs !== OBS_IM) begin errors++; $display("FAIL nest_im obs=%b want=%b", obs, OBS_IM); end
    tick();
    dcache_miss = 1'b1;
    #1;
    checks++; if (obs !== OBS_IMD) begin errors++; $display("FAIL nest_dmiss_in_im obs=%b want=%b", obs, OBS_IMD); end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      dcache_fill_done = (i == 2);
      #1;
      checks++; if (obs !== OBS_DM) begin errors++; $display("FAIL nest_dm%0d obs=%b want=%b", i, obs, OBS_DM); end
      tick();
    end
    idle();
    #1;
    checks++; if (obs !== OBS_IM) begin errors++; $display("FAIL nest_back_im obs=%b want=%b", obs, OBS_IM); end
    tick();
    icache_fill_done = 1'b1;
    #1;
    checks++; if (obs !== OBS_IM) begin errors++; $display("FAIL nest_im_fill obs=%b want=%b", obs, OBS_IM); end
    tick(); idle();
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL nest_run obs=%b want=%b", obs, OBS_RUN); end

    // Instruction fill coinciding with the data miss leaves nothing pending.
    icache_miss = 1'b1; tick(); idle();
    dcache_miss = 1'b1; icache_fill_done = 1'b1;
    tick(); idle();
    dcache_fill_done = 1'b1;
    #1;
    checks++; if (obs !== OBS_DM) begin errors++; $display("FAIL simul_dm obs=%b want=%b", obs, OBS_DM); end
    tick(); idle();
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL simul_run obs=%b want=%b", obs, OBS_RUN); end

    // Instruction fill arriving during DMISS clears the pending miss.
    icache_miss = 1'b1; tick(); idle();
    dcache_miss = 1'b1; tick(); idle();
    icache_fill_done = 1'b1; tick(); idle();
    dcache_fill_done = 1'b1; tick(); idle();
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL dm_clear_run obs=%b want=%b", obs, OBS_RUN); end
  endtask

  task automatic test_halt_reset();
    // Reset in the middle of a data miss.
    idle(); dcache_miss = 1'b1; tick();
    #1;
    checks++; if (obs !== OBS_DM) begin errors++; $display("FAIL rst_pre_dm obs=%b want=%b", obs, OBS_DM); end
    rst = 1'b0;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL rst_mid_dm obs=%b want=%b", obs, OBS_RUN); end
    tick();
    rst = 1'b1; idle();
    #1;
    // Halt: registered halted, then state held against all traffic.
    id_halt = 1'b1;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL halt_decode obs=%b want=%b", obs, OBS_RUN); end
    tick(); idle();
    #1;
    checks++; if (obs !== OBS_HLT) begin errors++; $display("FAIL halt_enter obs=%b want=%b", obs, OBS_HLT); end
    for (int i = 0; i < 6; i++) begin
      dcache_miss = $urandom_range(0, 1); icache_miss = $urandom_range(0, 1);
      dcache_fill_done = $urandom_range(0, 1); icache_fill_done = $urandom_range(0, 1);
      id_branch_taken = $urandom_range(0, 1);
      tick();
      checks++; if (obs !== OBS_HLT) begin errors++; $display("FAIL halt_hold%0d obs=%b want=%b", i, obs, OBS_HLT); end
    end
    rst = 1'b0;
    #1;
    checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL halt_reset obs=%b want=%b", obs, OBS_RUN); end
    tick();
    rst = 1'b1; idle();
  endtask

  // Randomized traffic against a rule-level model of the controller.
  task automatic test_random();
    int         m_state;
    bit         m_pend;
    bit         m_halted;
    int         m_stall;
    int         halt_age;
    bit         lu, frozen, fetch_hold;
    logic [5:0] want_ctl;
    logic [8:0] want;
    int         nxt;

    rst = 1'b0; idle(); #1; rst = 1'b1;
    m_state = 0; m_pend = 0; m_halted = 0; m_stall = 0; halt_age = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      id_rs = 4'($urandom_range(0, 15));
      id_rt = 4'($urandom_range(0, 15));
      ex_rd = ($urandom_range(0, 2) == 0) ? id_rs : ($urandom_range(0, 1) ? id_rt : 4'($urandom_range(0, 15)));
      id_rs_used = $urandom_range(0, 1);
      id_rt_used = $urandom_range(0, 1);
      ex_memread = $urandom_range(0, 1);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_halt = ($urandom_range(0, 99) == 0);
      icache_miss = ($urandom_range(0, 11) == 0);
      dcache_miss = ($urandom_range(0, 15) == 0);
      icache_fill_done = ($urandom_range(0, 3) == 0);
      dcache_fill_done = ($urandom_range(0, 3) == 0);
      #1;

      lu = ex_memread && (ex_rd != 0) &&
           ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
      frozen     = (m_state == 2) || (m_state != 3 && dcache_miss);
      fetch_hold = (m_state == 3) || (m_state == 1) || (m_state == 0 && (icache_miss || lu));
      if (frozen)                                   want_ctl = 6'b000000;
      else if (fetch_hold)                          want_ctl = 6'b001101;
      else if (m_state == 0 && id_branch_taken)     want_ctl = 6'b111110;
      else                                          want_ctl = 6'b111100;
      want = {m_halted, 2'(m_state), want_ctl};

      checks++; if (obs !== want) begin errors++; $display("FAIL rnd_cyc%0d obs=%b want=%b", cyc, obs, want); end
`ifdef PIPE_CTRL_PERF_EN
      checks++; if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall_cyc%0d got=%0d want=%0d", cyc, stall_cycles, m_stall); end
`endif

      nxt = m_state;
      case (m_state)
        0: begin
          if (dcache_miss) begin nxt = 2; m_pend = 0; end
          else if (icache_miss) nxt = 1;
          else if (!lu && !id_branch_taken && id_halt) nxt = 3;
        end
        1: begin
          if (dcache_miss) begin nxt = 2; m_pend = !icache_fill_done; end
          else if (icache_fill_done) nxt = 0;
        end
        2: begin
          if (icache_fill_done) m_pend = 0;
          if (dcache_fill_done) begin nxt = m_pend ? 1 : 0; m_pend = 0; end
        end
        default: nxt = 3;
      endcase
      if (want_ctl[5] == 1'b0 && m_state != 3 && m_stall < 65535) m_stall++;
      m_state  = nxt;
      m_halted = (nxt == 3);

      tick();
      halt_age = (m_state == 3) ? halt_age + 1 : 0;
      if (halt_age > 3) begin
        rst = 1'b0;
        #1;
        checks++; if (obs !== OBS_RUN) begin errors++; $display("FAIL rnd_reset obs=%b want=%b", obs, OBS_RUN); end
        rst = 1'b1;
        m_state = 0; m_pend = 0; m_halted = 0; m_stall = 0; halt_age = 0;
      end
    end
    idle();
    rst = 1'b0; #1; rst = 1'b1;
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    idle();
    rst = 1'b0; #1; rst = 1'b1;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL perf_reset got=%0d want=0", stall_cycles); end
    ex_memread = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
    repeat (7) tick();
    idle();
    #1;
    checks++; if (stall_cycles !== 16'd7) begin errors++; $display("FAIL perf_seven got=%0d want=7", stall_cycles); end
    dcache_miss = 1'b1; tick(); idle();
    repeat (65540) @(posedge clk);
    #1;
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate got=%h want=ffff", stall_cycles); end
    rst = 1'b0; #1; rst = 1'b1;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL perf_clear got=%0d want=0", stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_imiss();
    test_nested_miss();
    test_halt_reset();
    test_random();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
